// File: rtl/cdma_wt_wgs_reader_pkg.sv
// Shared definitions for the CDMA weight-group-status reader: state encoding,
// descriptor field positions and default field widths.
package cdma_wt_wgs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int LAST_BIT  = 31;
    localparam int ID_MSB    = 30;
    localparam int CNT_LSB   = 0;

    localparam int DEF_ID_W  = 7;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/cdma_wt_wgs_reader.sv
// Consumer of the WGS FIFO: pops a group descriptor, passes num_beats weight beats,
// then emits one group-done token. Optional statistics counters: CDMA_WT_WGS_STAT_EN.
module cdma_wt_wgs_reader
    import cdma_wt_wgs_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wgs_req,
    input  logic [31:0]     wgs_data,
    output logic            wgs_ready,
    input  logic            wt_beat_valid,
    output logic            wt_beat_ready,
    output logic            grp_active,
    output logic [ID_W-1:0] grp_id,
    output logic            grp_done_valid,
    input  logic            grp_done_ready,
    output logic [ID_W-1:0] grp_done_id,
    output logic            grp_done_last
`ifdef CDMA_WT_WGS_STAT_EN
    ,
    output logic [31:0]     wgs_grp_cnt,
    output logic [15:0]     wgs_null_cnt
`endif
);

    state_t            state;
    logic [CNT_W-1:0]  remaining;

    logic [ID_W-1:0]   dsc_id;
    logic              dsc_last;
    logic [CNT_W-1:0]  dsc_cnt;
    logic              pop;
    logic              beat;
    logic              done_hs;
    logic              unused_data;

    assign dsc_id      = wgs_data[ID_MSB -: ID_W];
    assign dsc_last    = wgs_data[LAST_BIT];
    assign dsc_cnt     = wgs_data[CNT_LSB +: CNT_W];
    assign unused_data = ^wgs_data;

    assign pop     = wgs_req && wgs_ready;
    assign beat    = wt_beat_valid && wt_beat_ready;
    assign done_hs = grp_done_valid && grp_done_ready;

    // All handshake outputs are registers updated alongside the state, so no
    // input ever reaches a ready output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            wgs_ready      <= 1'b0;
            wt_beat_ready  <= 1'b0;
            grp_active     <= 1'b0;
            grp_done_valid <= 1'b0;
            grp_id         <= '0;
            grp_done_id    <= '0;
            grp_done_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wgs_ready <= 1'b1;
                    if (pop) begin
                        wgs_ready     <= 1'b0;
                        grp_id        <= dsc_id;
                        grp_done_id   <= dsc_id;
                        grp_done_last <= dsc_last;
                        remaining     <= dsc_cnt;
                        if (dsc_cnt != '0) begin
                            state         <= ACTIVE;
                            wt_beat_ready <= 1'b1;
                            grp_active    <= 1'b1;
                        end else begin
                            state          <= DONE;
                            grp_done_valid <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (beat && remaining != '0) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state          <= DONE;
                            wt_beat_ready  <= 1'b0;
                            grp_active     <= 1'b0;
                            grp_done_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (done_hs) begin
                        state          <= IDLE;
                        grp_done_valid <= 1'b0;
                        wgs_ready      <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    wgs_ready      <= 1'b0;
                    wt_beat_ready  <= 1'b0;
                    grp_active     <= 1'b0;
                    grp_done_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CDMA_WT_WGS_STAT_EN
    // A pop can only happen in IDLE, so pop with a zero count is a null group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wgs_grp_cnt  <= '0;
            wgs_null_cnt <= '0;
        end else begin
            if (done_hs)
                wgs_grp_cnt <= wgs_grp_cnt + 32'd1;
            if (pop && dsc_cnt == '0 && wgs_null_cnt != 16'hFFFF)
                wgs_null_cnt <= wgs_null_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdma_wt_wgs_reader.sv
// Scoreboard bench for cdma_wt_wgs_reader: a queue-based FIFO model feeds descriptors,
// expected group tokens are queued on push and compared when the token handshakes.
module tb_cdma_wt_wgs_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wgs_req = 1'b0;
    logic [31:0] wgs_data = 32'h0;
    logic        wgs_ready;
    logic        wt_beat_valid = 1'b0;
    logic        wt_beat_ready;
    logic        grp_active;
    logic [6:0]  grp_id;
    logic        grp_done_valid;
    logic        grp_done_ready = 1'b0;
    logic [6:0]  grp_done_id;
    logic        grp_done_last;
`ifdef CDMA_WT_WGS_STAT_EN
    logic [31:0] wgs_grp_cnt;
    logic [15:0] wgs_null_cnt;
`endif

    always #5 clk = ~clk;

    cdma_wt_wgs_reader dut (
        .clk            (clk),
        .reset          (reset),
        .wgs_req        (wgs_req),
        .wgs_data       (wgs_data),
        .wgs_ready      (wgs_ready),
        .wt_beat_valid  (wt_beat_valid),
        .wt_beat_ready  (wt_beat_ready),
        .grp_active     (grp_active),
        .grp_id         (grp_id),
        .grp_done_valid (grp_done_valid),
        .grp_done_ready (grp_done_ready),
        .grp_done_id    (grp_done_id),
        .grp_done_last  (grp_done_last)
`ifdef CDMA_WT_WGS_STAT_EN
        ,
        .wgs_grp_cnt    (wgs_grp_cnt),
        .wgs_null_cnt   (wgs_null_cnt)
`endif
    );

    typedef struct {
        logic [6:0] id;
        logic       last;
        int         beats;
    } exp_t;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          cyc;
    logic        ev_pop, ev_beat, ev_done;
    int          pop_cyc, done_cyc, beats_seen, rdy_seen;
    int          exp_grp;
    int          exp_null;

    task automatic push_desc(input logic last, input logic [6:0] id, input logic [15:0] beats);
        fifo_q.push_back({last, id, 8'h00, beats});
        exp_q.push_back('{id: id, last: last, beats: int'(beats)});
    endtask

    // One clock: drive inputs at the negedge, note which handshakes will be taken
    // at the next posedge, then advance to the following negedge.
    task automatic run_cycle(input logic bv, input logic dr);
        wgs_req        = (fifo_q.size() != 0);
        wgs_data       = wgs_req ? fifo_q[0] : 32'h0;
        wt_beat_valid  = bv;
        grp_done_ready = dr;
        #1;
        ev_pop  = wgs_req && wgs_ready;
        ev_beat = bv && wt_beat_ready;
        ev_done = grp_done_valid && dr;
        if (ev_pop) begin
            pop_cyc    = cyc;
            beats_seen = 0;
            rdy_seen   = 0;
            if (fifo_q[0][15:0] == 16'h0 && exp_null < 65535) exp_null++;
        end
        if (wt_beat_ready) rdy_seen++;
        if (ev_beat) beats_seen++;
        if (ev_done) begin
            done_cyc = cyc;
            exp_grp++;
        end
        @(posedge clk);
        @(negedge clk);
        if (ev_pop) void'(fifo_q.pop_front());
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        wgs_req = 1'b0;
        wt_beat_valid = 1'b0;
        grp_done_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        exp_grp = 0;
        exp_null = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wgs_ready, wt_beat_ready, grp_active, grp_done_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", {wgs_ready, wt_beat_ready, grp_active, grp_done_valid});
        end
        checks++;
        if ({grp_id, grp_done_id, grp_done_last} !== 15'h0) begin
            errors++;
            $display("FAIL reset_ids: got %h expected 0", {grp_id, grp_done_id, grp_done_last});
        end
        apply_reset();
        run_cycle(1'b0, 1'b0);
        checks++;
        if (wgs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wgs_ready_rise: got %b expected 1", wgs_ready);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        bit   got = 0;
        apply_reset();
        push_desc(1'b1, 7'd5, 16'd3);
        for (int i = 0; i < 20 && !got; i++) begin
            run_cycle(1'b1, 1'b1);
            if (ev_done) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (grp_done_id !== e.id || grp_done_last !== e.last) begin
                    errors++;
                    $display("FAIL basic_token: got id=%0d last=%b expected id=%0d last=%b", grp_done_id, grp_done_last, e.id, e.last);
                end
                checks++;
                if (beats_seen != e.beats || rdy_seen != 3) begin
                    errors++;
                    $display("FAIL basic_beats: got beats=%0d ready_cycles=%0d expected 3/3", beats_seen, rdy_seen);
                end
                checks++;
                if (pop_cyc != 1 || done_cyc != 5) begin
                    errors++;
                    $display("FAIL basic_timing: got pop=%0d done=%0d expected 1/5", pop_cyc, done_cyc);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL basic_timeout: got no token expected one");
        end else if (wgs_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_rearm: got wgs_ready=%b expected 1", wgs_ready);
        end
    endtask

    task automatic test_null();
        exp_t e;
        bit   got = 0;
        push_desc(1'b0, 7'd10, 16'd0);
        for (int i = 0; i < 10 && !got; i++) begin
            run_cycle(1'b1, 1'b1);
            if (ev_done) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (grp_done_id !== e.id || grp_done_last !== e.last) begin
                    errors++;
                    $display("FAIL null_token: got id=%0d last=%b expected id=%0d last=%b", grp_done_id, grp_done_last, e.id, e.last);
                end
                checks++;
                if (beats_seen != 0 || rdy_seen != 0 || done_cyc != pop_cyc + 1) begin
                    errors++;
                    $display("FAIL null_path: got beats=%0d ready_cycles=%0d latency=%0d expected 0/0/1", beats_seen, rdy_seen, done_cyc - pop_cyc);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL null_timeout: got no token expected one");
        end
`ifdef CDMA_WT_WGS_STAT_EN
        checks++;
        if (wgs_null_cnt !== 16'(exp_null)) begin
            errors++;
            $display("FAIL null_cnt: got %0d expected %0d", wgs_null_cnt, exp_null);
        end
`endif
    endtask

    task automatic test_bubbles();
        exp_t e;
        bit   got = 0;
        bit   popped = 0;
        logic bv;
        push_desc(1'b0, 7'd3, 16'd4);
        for (int i = 0; i < 30 && !got; i++) begin
            bv = popped && (((cyc - pop_cyc) % 2) == 1);
            run_cycle(bv, 1'b1);
            if (ev_pop) popped = 1;
            if (ev_done) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (beats_seen != e.beats || done_cyc - pop_cyc != 8) begin
                    errors++;
                    $display("FAIL bubbles: got beats=%0d done_latency=%0d expected %0d/8", beats_seen, done_cyc - pop_cyc, e.beats);
                end
                checks++;
                if (grp_done_id !== e.id) begin
                    errors++;
                    $display("FAIL bubbles_id: got %0d expected %0d", grp_done_id, e.id);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bubbles_timeout: got no token expected one");
        end
    endtask

    task automatic test_done_stall();
        exp_t e;
        bit   got = 0;
        int   d = 0;
        push_desc(1'b1, 7'd20, 16'd2);
        push_desc(1'b0, 7'd21, 16'd1);
        for (int i = 0; i < 20 && grp_done_valid !== 1'b1; i++) run_cycle(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (grp_done_valid !== 1'b1 || grp_done_id !== 7'd20 || grp_done_last !== 1'b1 || wgs_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b id=%0d last=%b wgs_ready=%b expected 1/20/1/0", grp_done_valid, grp_done_id, grp_done_last, wgs_ready);
            end
            run_cycle(1'b1, 1'b0);
        end
        run_cycle(1'b1, 1'b1);
        checks++;
        if (!ev_done) begin
            errors++;
            $display("FAIL stall_release: got no handshake expected one");
        end else begin
            d = done_cyc;
            e = exp_q.pop_front();
            if (grp_done_id !== e.id) begin
                errors++;
                $display("FAIL stall_release: got id=%0d expected %0d", grp_done_id, e.id);
            end
        end
        run_cycle(1'b1, 1'b1);
        checks++;
        if (!ev_pop || pop_cyc != d + 1) begin
            errors++;
            $display("FAIL stall_next_pop: got pop=%b at %0d expected pop at %0d", ev_pop, pop_cyc, d + 1);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            run_cycle(1'b1, 1'b1);
            if (ev_done) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (grp_done_id !== e.id || grp_done_last !== e.last || beats_seen != e.beats) begin
                    errors++;
                    $display("FAIL stall_second: got id=%0d last=%b beats=%0d expected %0d/%b/%0d", grp_done_id, grp_done_last, beats_seen, e.id, e.last, e.beats);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stall_timeout: got no second token expected one");
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got = 0;
        push_desc(1'b1, 7'd7, 16'd7);
        for (int i = 0; i < 20 && beats_seen < 2; i++) run_cycle(1'b1, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if ({wgs_ready, wt_beat_ready, grp_active, grp_done_valid} !== 4'b0000 ||
            {grp_id, grp_done_id, grp_done_last} !== 15'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b%b act=%b dv=%b ids=%h expected all 0",
                     wgs_ready, wt_beat_ready, grp_active, grp_done_valid, {grp_id, grp_done_id, grp_done_last});
        end
`ifdef CDMA_WT_WGS_STAT_EN
        checks++;
        if (wgs_grp_cnt !== 32'h0 || wgs_null_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midreset_stats: got %0d/%0d expected 0/0", wgs_grp_cnt, wgs_null_cnt);
        end
`endif
        apply_reset();
        run_cycle(1'b0, 1'b1);
        checks++;
        if (wgs_ready !== 1'b1 || grp_active !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got wgs_ready=%b active=%b expected 1/0", wgs_ready, grp_active);
        end
        push_desc(1'b0, 7'd9, 16'd2);
        for (int i = 0; i < 20 && !got; i++) begin
            run_cycle(1'b1, 1'b1);
            if (ev_done) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (grp_done_id !== e.id || beats_seen != e.beats || done_cyc - pop_cyc != 3) begin
                    errors++;
                    $display("FAIL midreset_fresh: got id=%0d beats=%0d latency=%0d expected %0d/%0d/3", grp_done_id, beats_seen, done_cyc - pop_cyc, e.id, e.beats);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midreset_timeout: got no token expected one");
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   pops[3];
        int   n_pop = 0;
        int   n_done = 0;
        push_desc(1'b0, 7'd1, 16'hFFFF);
        push_desc(1'b0, 7'd2, 16'd3);
        push_desc(1'b1, 7'd3, 16'd1);
        for (int i = 0; i < 70000 && n_done < 3; i++) begin
            run_cycle(1'b1, 1'b1);
            if (ev_pop && n_pop < 3) begin
                pops[n_pop] = cyc - 1;
                n_pop++;
            end
            if (ev_done) begin
                n_done++;
                e = exp_q.pop_front();
                checks++;
                if (grp_done_id !== e.id || grp_done_last !== e.last || beats_seen != e.beats) begin
                    errors++;
                    $display("FAIL b2b_token: got id=%0d last=%b beats=%0d expected %0d/%b/%0d", grp_done_id, grp_done_last, beats_seen, e.id, e.last, e.beats);
                end
            end
        end
        checks++;
        if (n_done != 3 || n_pop != 3) begin
            errors++;
            $display("FAIL b2b_timeout: got pops=%0d dones=%0d expected 3/3", n_pop, n_done);
        end else if (pops[1] - pops[0] != 65537 || pops[2] - pops[1] != 5) begin
            errors++;
            $display("FAIL b2b_period: got %0d/%0d expected 65537/5", pops[1] - pops[0], pops[2] - pops[1]);
        end
`ifdef CDMA_WT_WGS_STAT_EN
        checks++;
        if (wgs_grp_cnt !== 32'(exp_grp) || wgs_null_cnt !== 16'(exp_null)) begin
            errors++;
            $display("FAIL b2b_stats: got %0d/%0d expected %0d/%0d", wgs_grp_cnt, wgs_null_cnt, exp_grp, exp_null);
        end
`endif
    endtask

    initial begin
        cyc = 0;
        pop_cyc = 0;
        done_cyc = 0;
        beats_seen = 0;
        rdy_seen = 0;
        exp_grp = 0;
        exp_null = 0;
        test_reset();
        test_basic();
        test_null();
        test_bubbles();
        test_done_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdma_wt_wgs_reader.md
Name: cdma_wt_wgs_reader

Overview:
Consumer end of the CDMA weight-group-status (WGS) FIFO.
- Pops one 32-bit group descriptor at a time using the FIFO's valid/ready read handshake.
- Decodes the group id, the beat count and the last-group flag.
- Gates the matching number of weight-data beats through to the convolution buffer writer.
- Emits one group-done token per descriptor.
- Sits between the WGS FIFO read port and the CDMA weight-to-CBUF pack logic.

Parameters:
- CNT_W, 16, width of the num_beats field and of the remaining-beat counter; legal range 1..16.
- ID_W, 7, width of the group-id field; ID_W+CNT_W ≤ 31.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- wgs_req  in  1  FIFO read-side valid (connects to the FIFO rd_req).
- wgs_data  in  32  descriptor: [31]=last, [30:31-ID_W]=group id, [CNT_W-1:0]=num_beats, other bits ignored.
- wgs_ready  out  1  pop strobe toward the FIFO (connects to the FIFO rd_ready).
- wt_beat_valid  in  1  weight beat offered by upstream.
- wt_beat_ready  out  1  beat accepted when valid&&ready.
- grp_active  out  1  a group is in progress (ACTIVE state).
- grp_id  out  ID_W  id of the current or most recent group.
- grp_done_valid  out  1  group-done token.
- grp_done_ready  in  1  token consumer ready.
- grp_done_id  out  ID_W  id carried with the token.
- grp_done_last  out  1  last flag carried with the token.

Behaviour:
- Reset:
  - state=IDLE; remaining counter = 0; grp_id, grp_done_id, grp_done_last = 0.
  - All valid/ready outputs = 0 while reset is high.
  - wgs_ready rises on the first clk edge after reset deasserts.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - wgs_ready=1, wt_beat_ready=0.
  - Pop handshake (wgs_req&&wgs_ready) at cycle T: register id and last, load remaining=num_beats.
  - num_beats≠0: go to ACTIVE at T+1.
  - num_beats==0 (null group): go directly to DONE at T+1; no beats are consumed.
- ACTIVE:
  - wgs_ready=0, wt_beat_ready=1, grp_active=1.
  - Each beat handshake decrements remaining.
  - The handshake taken when remaining==1 moves the FSM to DONE next cycle. The counter never underflows.
  - wt_beat_valid low inserts bubbles; there is no timeout.
- DONE:
  - grp_done_valid=1; grp_done_id and grp_done_last are stable until handshake.
  - wt_beat_ready=0 and wgs_ready=0.
  - grp_done_valid&&grp_done_ready returns the FSM to IDLE next cycle.
- Ready outputs are decoded from registered state only. There is no combinational path from any input to any ready output.
- Throughput: minimum per-group cycles = 1 (pop) + num_beats + 1 (done), with a zero-stall consumer.
- Beats offered in IDLE or DONE are held off (ready=0) and never dropped.
- wgs_data is sampled only on the pop cycle; it is don't-care otherwise.
- Reset asserted mid-group: the popped descriptor and its remaining count are discarded. The FSM returns to IDLE; the FIFO and upstream are reset by the same reset.
- grp_id updates on every pop and holds after DONE.

Optional Feature:
Macro CDMA_WT_WGS_STAT_EN.
- Defined: adds two outputs.
  - wgs_grp_cnt[31:0]: increments on every grp_done handshake; wraps at 2^32.
  - wgs_null_cnt[15:0]: increments on every null-group pop; saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package cdma_wt_wgs_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2).
  - Descriptor bit-position constants: LAST_BIT=31, ID_MSB=30, CNT_LSB=0.
  - Default ID_W and CNT_W.
- No sub-module; decode, counter and FSM are inline. Estimated 150–250 lines.

Test Plan:
1. Reset, then push descriptor 32'h8500_0003 (last=1, id=5, beats=3) and offer 3 continuous beats.
   - Pop occurs at cycle 1 after reset release.
   - wt_beat_ready is high for exactly 3 handshakes.
   - grp_done_valid appears with id=5 and last=1; wgs_ready is high again 1 cycle after the done handshake.
2. Null descriptor 32'h0A00_0000.
   - IDLE→DONE with no beat handshake (wt_beat_ready never rises).
   - grp_done_id=10.
   - With STAT_EN: wgs_null_cnt=1.
3. Descriptor with beats=4, wt_beat_valid toggling 1,0,1,0,…
   - Exactly 4 handshakes over 8 cycles; DONE is entered only after the 4th.
4. Hold grp_done_ready=0 for 10 cycles.
   - grp_done_valid, id and last stay stable.
   - wgs_ready=0 throughout, with a second descriptor waiting in the FIFO.
   - That descriptor pops in the cycle after IDLE is re-entered.
5. Assert reset in ACTIVE after 2 of 7 beats.
   - All outputs are 0 in the same cycle.
   - After release: state=IDLE, and the next descriptor is processed with a fresh count.
6. Back-to-back 3 groups of beats=65535 (CNT_W=16, max count).
   - No underflow; each group takes 65537 cycles.
   - With STAT_EN: wgs_grp_cnt=3.
